// File: rtl/vx_wb_pkg.sv
// Shared types and widths for the commit/writeback path.
// Config macros NUM_THREADS, NUM_WARPS and NUM_REGS default to 4/4/32 when not supplied.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NUM_REGS
`define NUM_REGS 32
`endif

package vx_wb_pkg;

   localparam int unsigned NUM_THREADS = `NUM_THREADS;
   localparam int unsigned NUM_WARPS   = `NUM_WARPS;
   localparam int unsigned NUM_REGS    = `NUM_REGS;
   localparam int unsigned WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int unsigned RD_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned DATA_W      = NUM_THREADS * 32;

   // One register-file write beat
   typedef struct packed {
      logic [WID_W-1:0]       wid;
      logic [31:0]            pc;
      logic [NUM_THREADS-1:0] tmask;
      logic [RD_W-1:0]        rd;
      logic [DATA_W-1:0]      data;
   } wb_beat_t;

   // Instructions without a write, or targeting the hardwired zero register, never reach the GPRs
   function automatic logic is_nowrite(input logic wb, input logic [RD_W-1:0] rd);
      return (!wb) || (rd == '0);
   endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer, wrapping,
// and advances the pointer past the winner on every grant.
module vx_rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [N-1:0]                          req,
   input  logic                                  enable,
   output logic [N-1:0]                          grant_onehot,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0]  grant_idx,
   output logic                                  grant_valid
);

   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

   logic [IDX_W-1:0] ptr;
   int unsigned      j;

   // Priority scan starting at the pointer
   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      grant_valid  = 1'b0;
      j            = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = 32'(ptr) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (enable && !grant_valid && req[IDX_W'(j)]) begin
            grant_valid                = 1'b1;
            grant_idx                  = IDX_W'(j);
            grant_onehot[IDX_W'(j)]    = 1'b1;
         end
      end
   end

   // Pointer moves to the slot after the winner; holds without a grant
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (grant_valid) begin
         ptr <= (32'(grant_idx) == (N - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/vx_commit_writeback.sv
// Commit-to-writeback collector: drops no-write commits, round-robins the rest
// into a single registered writeback channel.
// Optional macro VX_WB_PERF_EN adds perf_stall_cycles / perf_writes counters.
module vx_commit_writeback
   import vx_wb_pkg::*;
#(
   parameter int unsigned NUM_SRCS = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_SRCS-1:0]             cmt_valid,
   output logic [NUM_SRCS-1:0]             cmt_ready,
   input  logic [NUM_SRCS*WID_W-1:0]       cmt_wid,
   input  logic [NUM_SRCS*32-1:0]          cmt_pc,
   input  logic [NUM_SRCS*NUM_THREADS-1:0] cmt_tmask,
   input  logic [NUM_SRCS*RD_W-1:0]        cmt_rd,
   input  logic [NUM_SRCS-1:0]             cmt_wb,
   input  logic [NUM_SRCS*DATA_W-1:0]      cmt_data,
   output logic                            wb_valid,
   input  logic                            wb_ready,
   output logic [WID_W-1:0]                wb_wid,
   output logic [31:0]                     wb_pc,
   output logic [NUM_THREADS-1:0]          wb_tmask,
   output logic [RD_W-1:0]                 wb_rd,
   output logic [DATA_W-1:0]               wb_data
`ifdef VX_WB_PERF_EN
   ,
   output logic [63:0]                     perf_stall_cycles,
   output logic [63:0]                     perf_writes
`endif
);

   localparam int unsigned IDX_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

   wb_beat_t            src_beat [NUM_SRCS];
   wb_beat_t            sel_beat;
   wb_beat_t            beat_q;
   logic [NUM_SRCS-1:0] req;
   logic [NUM_SRCS-1:0] nowrite;
   logic [NUM_SRCS-1:0] grant_onehot;
   logic [IDX_W-1:0]    grant_idx;
   logic                grant_valid;
   logic                load;

   // Unpack flat commit buses and classify each source
   always_comb begin
      req     = '0;
      nowrite = '0;
      for (int i = 0; i < NUM_SRCS; i++) begin
         src_beat[i].wid   = cmt_wid[i*WID_W +: WID_W];
         src_beat[i].pc    = cmt_pc[i*32 +: 32];
         src_beat[i].tmask = cmt_tmask[i*NUM_THREADS +: NUM_THREADS];
         src_beat[i].rd    = cmt_rd[i*RD_W +: RD_W];
         src_beat[i].data  = cmt_data[i*DATA_W +: DATA_W];
         nowrite[i]        = is_nowrite(cmt_wb[i], cmt_rd[i*RD_W +: RD_W]);
         req[i]            = cmt_valid[i] & ~nowrite[i];
      end
   end

   assign load = ~wb_valid | wb_ready;

   vx_rr_arbiter #(
      .N (NUM_SRCS)
   ) u_arb (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .enable       (load & ~reset),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx),
      .grant_valid  (grant_valid)
   );

   assign sel_beat  = src_beat[grant_idx];
   assign cmt_ready = {NUM_SRCS{~reset}} & ((cmt_valid & nowrite) | grant_onehot);

   // Output valid: refill on handshake or when empty; reset drops any held beat
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_valid <= 1'b0;
      end else if (load) begin
         wb_valid <= grant_valid;
      end
   end

   // Output payload: captured only with a new grant, otherwise held
   always_ff @(posedge clk) begin
      if (load && grant_valid) begin
         beat_q <= sel_beat;
      end
   end

   assign wb_wid   = beat_q.wid;
   assign wb_pc    = beat_q.pc;
   assign wb_tmask = beat_q.tmask;
   assign wb_rd    = beat_q.rd;
   assign wb_data  = beat_q.data;

`ifdef VX_WB_PERF_EN
   // Cycles where some write request waited without a grant
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_cycles <= '0;
      end else if ((|req) && !grant_valid) begin
         perf_stall_cycles <= perf_stall_cycles + 64'd1;
      end
   end

   // Completed writeback handshakes
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_writes <= '0;
      end else if (wb_valid && wb_ready) begin
         perf_writes <= perf_writes + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vx_commit_writeback.sv
// Scoreboard bench for vx_commit_writeback: stimulus predicts grants from the
// round-robin rules and queues expected beats; a monitor checks the wb channel.
module tb_vx_commit_writeback;
   import vx_wb_pkg::*;

   localparam int NS = 4;

   logic                        clk;
   logic                        reset;
   logic [NS-1:0]               cmt_valid;
   logic [NS-1:0]               cmt_ready;
   logic [NS*WID_W-1:0]         cmt_wid;
   logic [NS*32-1:0]            cmt_pc;
   logic [NS*NUM_THREADS-1:0]   cmt_tmask;
   logic [NS*RD_W-1:0]          cmt_rd;
   logic [NS-1:0]               cmt_wb;
   logic [NS*DATA_W-1:0]        cmt_data;
   logic                        wb_valid;
   logic                        wb_ready;
   logic [WID_W-1:0]            wb_wid;
   logic [31:0]                 wb_pc;
   logic [NUM_THREADS-1:0]      wb_tmask;
   logic [RD_W-1:0]             wb_rd;
   logic [DATA_W-1:0]           wb_data;

   vx_commit_writeback #(.NUM_SRCS(NS)) dut (
      .clk(clk), .reset(reset),
      .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_wid(cmt_wid), .cmt_pc(cmt_pc),
      .cmt_tmask(cmt_tmask), .cmt_rd(cmt_rd), .cmt_wb(cmt_wb), .cmt_data(cmt_data),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wid(wb_wid), .wb_pc(wb_pc),
      .wb_tmask(wb_tmask), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit done     = 0;

   // Source-side pending transactions
   bit                      s_valid [NS];
   bit                      s_wb    [NS];
   logic [WID_W-1:0]        s_wid   [NS];
   logic [31:0]             s_pc    [NS];
   logic [NUM_THREADS-1:0]  s_tmask [NS];
   logic [RD_W-1:0]         s_rd    [NS];
   logic [DATA_W-1:0]       s_data  [NS];

   // Reference model state
   wb_beat_t exp_q[$];
   int       ptr = 0;

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] d;
      for (int l = 0; l < NUM_THREADS; l++) d[l*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic load_src(input int i, input bit wb, input logic [RD_W-1:0] rd);
      s_valid[i] = 1;
      s_wb[i]    = wb;
      s_rd[i]    = rd;
      s_wid[i]   = WID_W'($urandom);
      s_pc[i]    = $urandom;
      s_tmask[i] = NUM_THREADS'($urandom);
      s_data[i]  = rand_data();
   endtask

   function automatic logic [RD_W-1:0] rand_rd_nz();
      logic [RD_W-1:0] r;
      r = RD_W'($urandom_range(1, NUM_REGS - 1));
      return r;
   endfunction

   // One cycle: drive, predict readies/grant, check readies, then update model after the edge
   task automatic step(input bit rdy, input bit rst);
      int          g;
      bit [NS-1:0] exp_rdy;
      bit          load;
      wb_beat_t    gb;
      @(negedge clk);
      reset    = rst;
      wb_ready = rdy;
      for (int i = 0; i < NS; i++) begin
         cmt_valid[i]                        = s_valid[i];
         cmt_wb[i]                           = s_wb[i];
         cmt_wid[i*WID_W +: WID_W]           = s_wid[i];
         cmt_pc[i*32 +: 32]                  = s_pc[i];
         cmt_tmask[i*NUM_THREADS +: NUM_THREADS] = s_tmask[i];
         cmt_rd[i*RD_W +: RD_W]              = s_rd[i];
         cmt_data[i*DATA_W +: DATA_W]        = s_data[i];
      end
      #1;
      load = (exp_q.size() == 0) || rdy;
      g = -1;
      if (!rst && load) begin
         for (int k = 0; k < NS; k++) begin
            int j;
            j = (ptr + k) % NS;
            if (g < 0 && s_valid[j] && s_wb[j] && s_rd[j] != 0) g = j;
         end
      end
      for (int i = 0; i < NS; i++)
         exp_rdy[i] = (!rst && s_valid[i] && (!s_wb[i] || s_rd[i] == 0)) || (i == g);
      checks++;
      if (cmt_ready !== exp_rdy) begin
         failures++;
         $display("FAIL cmt_ready t=%0t got=%b want=%b", $time, cmt_ready, exp_rdy);
      end
      if (g >= 0) gb = '{wid: s_wid[g], pc: s_pc[g], tmask: s_tmask[g], rd: s_rd[g], data: s_data[g]};
      else gb = '0;
      for (int i = 0; i < NS; i++) if (exp_rdy[i]) s_valid[i] = 0;
      @(posedge clk);
      #1;
      if (rst) begin
         exp_q.delete();
         ptr = 0;
      end else if (g >= 0) begin
         exp_q.push_back(gb);
         ptr = (g + 1) % NS;
      end
   endtask

   // Monitor: wb_valid must match an expected beat; payload compared while held, popped on handshake
   initial begin
      wb_beat_t act;
      while (!done) begin
         @(negedge clk);
         #2;
         if (done) break;
         checks++;
         if (wb_valid !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL wb_valid t=%0t got=%b want=%b", $time, wb_valid, exp_q.size() != 0);
         end else if (wb_valid) begin
            act = '{wid: wb_wid, pc: wb_pc, tmask: wb_tmask, rd: wb_rd, data: wb_data};
            checks++;
            if (act !== exp_q[0]) begin
               failures++;
               $display("FAIL wb_beat t=%0t got pc=%h rd=%0d wid=%0d tm=%b data=%h want pc=%h rd=%0d wid=%0d tm=%b data=%h",
                        $time, act.pc, act.rd, act.wid, act.tmask, act.data,
                        exp_q[0].pc, exp_q[0].rd, exp_q[0].wid, exp_q[0].tmask, exp_q[0].data);
            end
            if (wb_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      reset = 1; wb_ready = 0; cmt_valid = '0; cmt_wb = '0; cmt_wid = '0; cmt_pc = '0;
      cmt_tmask = '0; cmt_rd = '0; cmt_data = '0;
      for (int i = 0; i < NS; i++) begin
         s_valid[i] = 0; s_wb[i] = 0; s_wid[i] = '0; s_pc[i] = '0;
         s_tmask[i] = '0; s_rd[i] = '0; s_data[i] = '0;
      end
      step(0, 1);
      step(0, 1);

      // Idle after reset
      for (int c = 0; c < 10; c++) step(1, 0);

      // Single directed write from source 0
      s_valid[0] = 1; s_wb[0] = 1; s_wid[0] = WID_W'(1); s_rd[0] = RD_W'(5);
      s_pc[0] = 32'h0000_1000; s_tmask[0] = NUM_THREADS'(4'b1011);
      s_data[0] = '0;
      s_data[0][31:0] = 32'h11; s_data[0][63:32] = 32'h22;
      s_data[0][95:64] = 32'h33; s_data[0][127:96] = 32'h44;
      step(1, 0);
      step(1, 0);
      step(1, 0);

      // All sources requesting continuously, sink always ready
      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < NS; i++) if (!s_valid[i]) load_src(i, 1, rand_rd_nz());
         step(1, 0);
      end
      for (int i = 0; i < NS; i++) s_valid[i] = 0;
      step(1, 0);
      step(1, 0);

      // Stall with a held beat; no-write source 2 still accepted
      load_src(0, 1, rand_rd_nz());
      step(1, 0);
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < NS; i++) if (!s_valid[i]) load_src(i, (i != 2), (i == 2) ? rand_rd_nz() : rand_rd_nz());
         step(0, 0);
      end
      for (int c = 0; c < 6; c++) step(1, 0);

      // rd=0 with wb=1 on source 1 is dropped
      load_src(1, 1, '0);
      step(1, 0);
      step(1, 0);
      step(1, 0);

      // Reset while a beat is held and stalled
      load_src(3, 1, rand_rd_nz());
      step(1, 0);
      load_src(1, 1, rand_rd_nz());
      load_src(2, 1, rand_rd_nz());
      step(0, 0);
      step(0, 1);
      step(1, 0);
      step(1, 0);
      step(1, 0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NS; i++)
            if (!s_valid[i] && ($urandom % 10) < 6)
               load_src(i, ($urandom % 5) != 0, (($urandom % 6) == 0) ? '0 : rand_rd_nz());
         step(($urandom % 4) != 0, ($urandom % 250) == 0);
      end

      // Drain
      for (int i = 0; i < NS; i++) s_valid[i] = 0;
      for (int c = 0; c < 8; c++) step(1, 0);

      done = 1;
      @(negedge clk);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vx_commit_writeback.md
Name: vx_commit_writeback

Overview:
- Write-side initiator for the per-core GPR file.
- Collects completed instructions from NUM_SRCS execute-unit commit ports (ALU, LSU, CSR, FPU, ...), drops those needing no register write, and round-robin arbitrates the rest.
- Drives one registered writeback channel (valid/ready) into the register-file stage.
- One write per cycle; back-pressure propagates per source.

Parameters:
- NUM_SRCS, 4, number of commit sources.
- NUM_THREADS, `NUM_THREADS, lanes per warp.
- NUM_WARPS, `NUM_WARPS, warps per core; WID_W = clog2(NUM_WARPS), min 1.
- NUM_REGS, `NUM_REGS, architectural registers; RD_W = clog2(NUM_REGS).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- cmt_valid  in  NUM_SRCS  source i has a committed instruction
- cmt_ready  out  NUM_SRCS  source i is accepted this cycle
- cmt_wid  in  NUM_SRCS*WID_W  warp id per source
- cmt_pc  in  NUM_SRCS*32  instruction PC per source
- cmt_tmask  in  NUM_SRCS*NUM_THREADS  thread mask per source
- cmt_rd  in  NUM_SRCS*RD_W  destination register per source
- cmt_wb  in  NUM_SRCS  1 = instruction writes rd
- cmt_data  in  NUM_SRCS*NUM_THREADS*32  per-lane result per source
- wb_valid  out  1  writeback valid
- wb_ready  in  1  register file accepts
- wb_wid  out  WID_W  warp id
- wb_pc  out  32  PC
- wb_tmask  out  NUM_THREADS  lane write mask
- wb_rd  out  RD_W  destination register
- wb_data  out  NUM_THREADS*32  lane data

Behaviour:
- Reset: wb_valid=0, round-robin pointer=0, cmt_ready=0, perf counters=0. Output payload regs are don't-care while wb_valid=0.
- Reset asserted mid-operation discards any held output beat. Sources must not assume that beat was written.
- Drop path: a source with cmt_valid=1 and either cmt_wb=0 or cmt_rd=0 is "no-write". It gets cmt_ready=1 in the same cycle, independent of arbitration and wb_ready. It is never forwarded.
- Write requests: req[i] = cmt_valid[i] & cmt_wb[i] & (cmt_rd[i]!=0).
- Output stage: single register. Define load = ~wb_valid | wb_ready.
- Arbitration:
  - When load=1 and any req is set, grant exactly one source: the first set req[] scanning upward from the pointer, wrapping at NUM_SRCS.
  - cmt_ready[g]=1 for the granted source. All other write requesters get cmt_ready=0 that cycle.
  - After a grant to g, the pointer becomes (g+1) mod NUM_SRCS. With no grant the pointer holds.
- Latency: a granted beat appears on wb_* on the next cycle, then holds stable until wb_valid & wb_ready.
- Throughput: with wb_ready tied high, one write per cycle, back-to-back.
- Simultaneous events: in one cycle, wb handshake completes and a new grant loads. wb_valid stays 1 with the new payload, no bubble. If no new grant, wb_valid goes to 0.
- Stall: while wb_valid=1 and wb_ready=0, no write requester receives ready. No-write sources are still accepted.
- Payload is copied unmodified, including tmask=0. No merging, reordering or coalescing.
- Combinational paths: cmt_ready depends combinationally on cmt_valid/wb/rd and wb_ready. wb_* outputs are registered only.
- cmt_ready is never asserted for a source whose cmt_valid=0.

Optional Feature:
- Macro: VX_WB_PERF_EN.
- Defined: adds output perf_stall_cycles (64 bits). It increments each cycle in which at least one req is set but receives no grant. It also adds perf_writes (64 bits), which increments on each wb_valid & wb_ready. Both clear on reset and wrap at 2^64.
- Undefined: these ports and counters do not exist. Functional behaviour is otherwise identical.

Decomposition:
- Package vx_wb_pkg holds:
  - typedef wb_beat_t: struct of wid, pc, tmask, rd, data.
  - localparams WID_W and RD_W derived from the config macros.
  - Helper function is_nowrite(wb, rd).
- Sub-module vx_rr_arbiter: parameter N; ports clk, reset, req[N], enable, grant_onehot[N], grant_idx, grant_valid; pointer update inside. It is reusable by other issue-side arbiters.

Test Plan:
- Reset then idle: no cmt_valid for 10 cycles -> wb_valid=0 throughout, all cmt_ready=0.
- Single source 0, wid=1, rd=5, tmask=4'b1011, data lanes 0x11/0x22/0x33/0x44 -> cmt_ready[0]=1 at cycle T; at T+1 wb_valid=1 with identical payload.
- All 4 sources request continuously, wb_ready=1 -> grants in order 0,1,2,3,0,...; one beat per cycle, no bubbles.
- wb_ready held 0 for 3 cycles with beat held -> wb_* stable; no write requester ready. Source 2 with cmt_wb=0 is accepted immediately during the stall.
- rd=0 with cmt_wb=1 on source 1 -> cmt_ready[1]=1 the same cycle; wb_valid never asserted for it.
- Reset pulsed while wb_valid=1, wb_ready=0 -> next cycle wb_valid=0 and pointer=0; after release the next grant goes to the lowest requesting index.
